// File: rtl/bank_timing_ctrl.sv
// bank_timing_ctrl: per-bank DRAM command legality checker and timing tracker.
// Each bank runs its own state machine and down-counter. The counter measures how
// long the bank has left in a timed state (activating, reading, writing, precharging
// or refreshing). Illegal commands are rejected. A rejection pulses cmd_err for one
// cycle and increments a saturating error counter.
//
// Ports:
//   clk        - rising-edge clock
//   reset_n    - asynchronous active-low reset
//   bg, ba     - bank-group / bank address; bank index = {bg,ba} (bg ignored if BGWIDTH=0)
//   ACT..REF   - command strobes, sampled on the rising edge
//   bank_state - 5-bit state per bank, bank k at [5k+4:5k]
//   cmd_err    - one-cycle pulse after a rejected command
//   err_cnt    - saturating count of rejected commands
//   any_busy   - combinational: some bank is in a timed state
module bank_timing_ctrl #(
  parameter int unsigned BGWIDTH = 2,
  parameter int unsigned BAWIDTH = 2,
  parameter int unsigned BL      = 8,
  parameter int unsigned T_RCD   = 17,
  parameter int unsigned T_WR    = 14,
  parameter int unsigned T_RP    = 17,
  parameter int unsigned T_RFC   = 34
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0]  bg,
  input  logic [BAWIDTH-1:0]                        ba,
  input  logic                                      ACT,
  input  logic                                      RD,
  input  logic                                      RDA,
  input  logic                                      WR,
  input  logic                                      WRA,
  input  logic                                      PR,
  input  logic                                      PRA,
  input  logic                                      REF,
  output logic [5*(2**(BGWIDTH+BAWIDTH))-1:0]       bank_state,
  output logic                                      cmd_err,
  output logic [7:0]                                err_cnt,
  output logic                                      any_busy
);

  localparam int unsigned NB    = 2**(BGWIDTH+BAWIDTH);
  localparam int unsigned IDXW  = BGWIDTH + BAWIDTH;
  localparam int unsigned MAX_A = (BL > T_RCD) ? BL : T_RCD;
  localparam int unsigned MAX_B = (T_WR > T_RP) ? T_WR : T_RP;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAXT  = (MAX_C > T_RFC) ? MAX_C : T_RFC;
  localparam int unsigned CW    = $clog2(MAXT + 1);

  // Counters load duration-1 on entry so the state lasts exactly the duration.
  localparam logic [CW-1:0] LD_BL  = CW'(BL - 1);
  localparam logic [CW-1:0] LD_RCD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] LD_WR  = CW'(T_WR - 1);
  localparam logic [CW-1:0] LD_RP  = CW'(T_RP - 1);
  localparam logic [CW-1:0] LD_RFC = CW'(T_RFC - 1);

  typedef enum logic [4:0] {
    S_IDLE        = 5'h00,
    S_ACTIVATING  = 5'h01,
    S_ACTIVE      = 5'h03,
    S_PRECHARGING = 5'h0a,
    S_READING     = 5'h0b,
    S_READING_AP  = 5'h0c,
    S_REFRESHING  = 5'h0d,
    S_WRITING     = 5'h12,
    S_WRITING_AP  = 5'h13
  } bank_st_e;

  bank_st_e        st  [NB];
  logic [CW-1:0]   cnt [NB];

  logic [7:0]      strobes;
  logic [IDXW-1:0] idx;
  bank_st_e        tgt;
  logic            all_idle;
  logic            any_timed;
  logic            cmd_ok;
  logic            accept;
  logic            reject;

  assign strobes = {ACT, RD, RDA, WR, WRA, PR, PRA, REF};

  // Command decode: legality against the addressed bank and the whole array.
  always_comb begin
    idx       = '0;
    all_idle  = 1'b1;
    any_timed = 1'b0;
    cmd_ok    = 1'b0;
    if (BGWIDTH == 0) idx = IDXW'(ba);
    else              idx = IDXW'({bg, ba});
    for (int k = 0; k < NB; k++) begin
      if (st[k] != S_IDLE) all_idle = 1'b0;
      if (st[k] != S_IDLE && st[k] != S_ACTIVE) any_timed = 1'b1;
    end
    tgt = st[idx];
    if (ACT)      cmd_ok = (tgt == S_IDLE);
    else if (RD || RDA || WR || WRA)
                  cmd_ok = (tgt == S_ACTIVE);
    else if (PR)  cmd_ok = (tgt == S_IDLE) || (tgt == S_ACTIVE);
    else if (PRA) cmd_ok = !any_timed;
    else if (REF) cmd_ok = all_idle;
    accept = $onehot(strobes) && cmd_ok;
    reject = (|strobes) && !accept;
  end

  // Per-bank state and counter update plus error tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NB; k++) begin
        st[k]  <= S_IDLE;
        cnt[k] <= '0;
      end
      cmd_err <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      cmd_err <= reject;
      if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      for (int k = 0; k < NB; k++) begin
        // A bank in a timed state never accepts a command, so timing and
        // command handling are mutually exclusive per bank.
        if (st[k] != S_IDLE && st[k] != S_ACTIVE) begin
          if (cnt[k] != '0) begin
            cnt[k] <= cnt[k] - CW'(1);
          end else begin
            case (st[k])
              S_ACTIVATING, S_READING, S_WRITING: st[k] <= S_ACTIVE;
              S_READING_AP, S_WRITING_AP: begin
                st[k]  <= S_PRECHARGING;
                cnt[k] <= LD_RP;
              end
              default: st[k] <= S_IDLE;
            endcase
          end
        end else if (accept) begin
          if (REF) begin
            st[k]  <= S_REFRESHING;
            cnt[k] <= LD_RFC;
          end else if (PRA) begin
            if (st[k] == S_ACTIVE) begin
              st[k]  <= S_PRECHARGING;
              cnt[k] <= LD_RP;
            end
          end else if (idx == IDXW'(k)) begin
            if (ACT) begin
              st[k] <= S_ACTIVATING; cnt[k] <= LD_RCD;
            end else if (RD) begin
              st[k] <= S_READING;    cnt[k] <= LD_BL;
            end else if (RDA) begin
              st[k] <= S_READING_AP; cnt[k] <= LD_BL;
            end else if (WR) begin
              st[k] <= S_WRITING;    cnt[k] <= LD_WR;
            end else if (WRA) begin
              st[k] <= S_WRITING_AP; cnt[k] <= LD_WR;
            end else if (PR && st[k] == S_ACTIVE) begin
              st[k] <= S_PRECHARGING; cnt[k] <= LD_RP;
            end
          end
        end
      end
    end
  end

  // Flatten per-bank state onto the output bus.
  always_comb begin
    bank_state = '0;
    for (int k = 0; k < NB; k++) bank_state[5*k +: 5] = st[k];
  end

  assign any_busy = any_timed;

endmodule

// File: tb/tb_bank_timing_ctrl.sv
// Directed bench for bank_timing_ctrl: drives commands on the falling edge and
// checks outputs on the falling edge against hand-computed expectations.
module tb_bank_timing_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic        ACT, RD, RDA, WR, WRA, PR, PRA, REF;
  logic [79:0] bank_state;
  logic        cmd_err;
  logic [7:0]  err_cnt;
  logic        any_busy;

  int tests = 0;
  int fails = 0;

  localparam logic [7:0] C_ACT = 8'h80, C_RD = 8'h40, C_RDA = 8'h20, C_WR = 8'h10,
                         C_WRA = 8'h08, C_PR = 8'h04, C_PRA = 8'h02, C_REF = 8'h01;

  bank_timing_ctrl dut (
    .clk(clk), .reset_n(reset_n), .bg(bg), .ba(ba),
    .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR), .PRA(PRA), .REF(REF),
    .bank_state(bank_state), .cmd_err(cmd_err), .err_cnt(err_cnt), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] bst(input int k);
    return bank_state[5*k +: 5];
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one strobe pattern at the current falling edge; returns on the
  // falling edge after the rising edge that sampled it.
  task automatic cmd(input logic [7:0] s, input int bank);
    logic [3:0] b;
    b = 4'(bank);
    bg = b[3:2];
    ba = b[1:0];
    {ACT, RD, RDA, WR, WRA, PR, PRA, REF} = s;
    @(negedge clk);
    {ACT, RD, RDA, WR, WRA, PR, PRA, REF} = 8'h00;
  endtask

  task automatic hold(input string tag, input int k, input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, 80'(bst(k)), 80'(v));
      @(negedge clk);
    end
  endtask

  task automatic hold_all(input string tag, input logic [4:0] v, input int n);
    logic [79:0] e;
    e = {16{v}};
    for (int i = 0; i < n; i++) begin
      chk(tag, bank_state, e);
      @(negedge clk);
    end
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [79:0] m5;

  initial begin
    m5 = 80'h1F << 25;
    reset_n = 1'b0;
    bg = '0; ba = '0;
    {ACT, RD, RDA, WR, WRA, PR, PRA, REF} = 8'h00;
    idle_wait(3);
    chk("rst_state", bank_state, 80'h0);
    chk("rst_err", 80'(cmd_err), 80'h0);
    chk("rst_cnt", 80'(err_cnt), 80'h0);
    chk("rst_busy", 80'(any_busy), 80'h0);
    reset_n = 1'b1;

    // Activate bank 5 on the first edge after reset release
    cmd(C_ACT, 5);
    chk("act_busy", 80'(any_busy), 80'h1);
    chk("act_others", bank_state & ~m5, 80'h0);
    hold("act5", 5, 5'h01, 17);
    chk("act5_done", 80'(bst(5)), 80'h03);
    chk("act_busy_off", 80'(any_busy), 80'h0);

    // WR, RD, PR
    cmd(C_WR, 5);  hold("wr5", 5, 5'h12, 14);
    chk("wr5_done", 80'(bst(5)), 80'h03);
    cmd(C_RD, 5);  hold("rd5", 5, 5'h0b, 8);
    chk("rd5_done", 80'(bst(5)), 80'h03);
    cmd(C_PR, 5);  hold("pr5", 5, 5'h0a, 17);
    chk("pr5_done", 80'(bst(5)), 80'h00);
    chk("seq_cmd_err", 80'(cmd_err), 80'h0);
    chk("seq_err_cnt", 80'(err_cnt), 80'h0);

    // WRA then RDA with auto-precharge
    cmd(C_ACT, 5); hold("act5b", 5, 5'h01, 17);
    cmd(C_WRA, 5); hold("wra5", 5, 5'h13, 14);
    hold("wra5_pre", 5, 5'h0a, 17);
    chk("wra5_done", 80'(bst(5)), 80'h00);
    cmd(C_ACT, 5); hold("act5c", 5, 5'h01, 17);
    cmd(C_RDA, 5); hold("rda5", 5, 5'h0c, 8);
    hold("rda5_pre", 5, 5'h0a, 17);
    chk("rda5_done", 80'(bst(5)), 80'h00);

    // REF rejected while a bank is active
    cmd(C_ACT, 5); idle_wait(17);
    chk("ref_pre_state", 80'(bst(5)), 80'h03);
    cmd(C_REF, 0);
    chk("ref_rej_err", 80'(cmd_err), 80'h1);
    chk("ref_rej_cnt", 80'(err_cnt), 80'h1);
    chk("ref_rej_state", 80'(bst(5)), 80'h03);
    @(negedge clk);
    chk("ref_rej_pulse", 80'(cmd_err), 80'h0);
    cmd(C_PR, 5); hold("pr5b", 5, 5'h0a, 17);

    // REF with all banks idle
    cmd(C_REF, 0);
    hold_all("ref_all", 5'h0d, 34);
    chk("ref_done", bank_state, 80'h0);
    chk("ref_cnt", 80'(err_cnt), 80'h1);

    // PR to an idle bank is a legal no-op
    cmd(C_PR, 7);
    chk("pr_idle_err", 80'(cmd_err), 80'h0);
    chk("pr_idle_state", bank_state, 80'h0);

    // PRA moves banks 0 and 5 together
    cmd(C_ACT, 0);
    cmd(C_ACT, 5);
    idle_wait(17);
    chk("pra_pre0", 80'(bst(0)), 80'h03);
    chk("pra_pre5", 80'(bst(5)), 80'h03);
    cmd(C_PRA, 0);
    chk("pra_b0", 80'(bst(0)), 80'h0a);
    chk("pra_b5", 80'(bst(5)), 80'h0a);
    chk("pra_err", 80'(cmd_err), 80'h0);
    hold("pra_hold0", 0, 5'h0a, 17);
    chk("pra_done", bank_state, 80'h0);

    // PRA rejected while bank 0 is activating
    cmd(C_ACT, 0);
    cmd(C_PRA, 0);
    chk("pra_rej_err", 80'(cmd_err), 80'h1);
    chk("pra_rej_cnt", 80'(err_cnt), 80'h2);
    chk("pra_rej_state", 80'(bst(0)), 80'h01);

    // Two strobes on the same edge
    cmd(C_ACT | C_RD, 5);
    chk("multi_err", 80'(cmd_err), 80'h1);
    chk("multi_cnt", 80'(err_cnt), 80'h3);
    chk("multi_state5", 80'(bst(5)), 80'h00);
    chk("multi_state0", 80'(bst(0)), 80'h01);
    idle_wait(16);
    chk("act0_done", 80'(bst(0)), 80'h03);

    // Asynchronous reset in the middle of WRITING
    cmd(C_WR, 0);
    idle_wait(3);
    chk("mid_wr", 80'(bst(0)), 80'h12);
    reset_n = 1'b0;
    #1;
    chk("async_state", bank_state, 80'h0);
    chk("async_cnt", 80'(err_cnt), 80'h0);
    chk("async_err", 80'(cmd_err), 80'h0);
    chk("async_busy", 80'(any_busy), 80'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cmd(C_ACT, 5);
    chk("post_others", bank_state & ~m5, 80'h0);
    hold("post_act5", 5, 5'h01, 17);
    chk("post_act5_done", 80'(bst(5)), 80'h03);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
